switch_event_scheduler: RTL

Converts up to NUM_SW debounced switch levels into classified button events: click, double-click, long-press and long-release. Each switch runs its own event FSM. A round-robin arbiter shares a single valid/ready event port among all switches. The block sits directly downstream of the per-switch debounce instances and replaces ad-hoc edge-detect/toggle logic in top levels.

---
 rtl/switch_event_pkg.sv | 23 ++
 rtl/switch_event_fsm.sv | 149 ++++++++++++++
 rtl/switch_event_scheduler.sv | 98 +++++++++
 3 files changed

// File: rtl/switch_event_pkg.sv
// Shared definitions for the switch event scheduler: event codes,
// channel state encoding and a counter-width helper.
package switch_event_pkg;

    localparam logic [1:0] EV_CLICK        = 2'd0;
    localparam logic [1:0] EV_DOUBLE       = 2'd1;
    localparam logic [1:0] EV_LONG         = 2'd2;
    localparam logic [1:0] EV_LONG_RELEASE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_WAIT_SECOND    = 3'd2,
        ST_SECOND_PRESSED = 3'd3,
        ST_LONG_HELD      = 3'd4
    } chan_state_t;

    // Bits needed to hold a count up to max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/switch_event_fsm.sv
// One switch channel: edge detect, click/double/long classifier FSM,
// saturating run counter and a one-deep pending event latch.
// The sample that causes a transition counts as the first qualifying
// sample, so LONG fires on the LONG_CYC-th high sample including the
// rising one (thresholds below are therefore CYC-2 in counter terms).
// Both cycle constants are expected to be at least 2.
module switch_event_fsm
    import switch_event_pkg::*;
#(
    parameter int LONG_CYC   = 20,
    parameter int DOUBLE_CYC = 10
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch,
    input  logic       i_Grant,
    output logic       o_Pending,
    output logic [1:0] o_Code,
    output logic       o_Drop,
    output logic       o_Held
);

    localparam int MAX_CYC = (LONG_CYC > DOUBLE_CYC) ? LONG_CYC : DOUBLE_CYC;
    localparam int CW      = cnt_width(MAX_CYC);
    localparam logic [CW-1:0] LONG_LAST   = CW'((LONG_CYC   >= 2) ? LONG_CYC   - 2 : 0);
    localparam logic [CW-1:0] DOUBLE_LAST = CW'((DOUBLE_CYC >= 2) ? DOUBLE_CYC - 2 : 0);

    logic          r_Prev;
    chan_state_t   r_State;
    chan_state_t   w_State_Next;
    logic [CW-1:0] r_Cnt;
    logic [CW-1:0] w_Cnt_Next;
    logic [CW-1:0] w_Cnt_Inc;
    logic          w_Rise;
    logic          w_Fall;
    logic          w_Emit;
    logic [1:0]    w_Emit_Code;
    logic          r_Pending;
    logic [1:0]    r_Code;
    logic          r_Drop;

    assign w_Rise    = i_Switch & ~r_Prev;
    assign w_Fall    = ~i_Switch & r_Prev;
    assign w_Cnt_Inc = (&r_Cnt) ? r_Cnt : r_Cnt + 1'b1;

    // Next-state, counter and event emission for the classifier
    always_comb begin
        w_State_Next = r_State;
        w_Cnt_Next   = r_Cnt;
        w_Emit       = 1'b0;
        w_Emit_Code  = EV_CLICK;
        case (r_State)
            ST_IDLE: begin
                if (w_Rise) begin
                    w_State_Next = ST_PRESSED;
                    w_Cnt_Next   = '0;
                end
            end
            ST_PRESSED, ST_SECOND_PRESSED: begin
                if (w_Fall) begin
                    w_Cnt_Next = '0;
                    if (r_State == ST_SECOND_PRESSED) begin
                        w_State_Next = ST_IDLE;
                        w_Emit       = 1'b1;
                        w_Emit_Code  = EV_DOUBLE;
                    end else begin
                        w_State_Next = ST_WAIT_SECOND;
                    end
                end else if (i_Switch) begin
                    if (r_Cnt >= LONG_LAST) begin
                        w_State_Next = ST_LONG_HELD;
                        w_Cnt_Next   = '0;
                        w_Emit       = 1'b1;
                        w_Emit_Code  = EV_LONG;
                    end else begin
                        w_Cnt_Next = w_Cnt_Inc;
                    end
                end
            end
            ST_LONG_HELD: begin
                if (w_Fall) begin
                    w_State_Next = ST_IDLE;
                    w_Emit       = 1'b1;
                    w_Emit_Code  = EV_LONG_RELEASE;
                end
            end
            ST_WAIT_SECOND: begin
                if (w_Rise) begin
                    w_State_Next = ST_SECOND_PRESSED;
                    w_Cnt_Next   = '0;
                end else if (!i_Switch) begin
                    if (r_Cnt >= DOUBLE_LAST) begin
                        w_State_Next = ST_IDLE;
                        w_Cnt_Next   = '0;
                        w_Emit       = 1'b1;
                        w_Emit_Code  = EV_CLICK;
                    end else begin
                        w_Cnt_Next = w_Cnt_Inc;
                    end
                end
            end
            default: begin
                w_State_Next = ST_IDLE;
                w_Cnt_Next   = '0;
            end
        endcase
    end

    // State, counter and previous-level registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State <= ST_IDLE;
            r_Cnt   <= '0;
            r_Prev  <= 1'b0;
        end else begin
            r_State <= w_State_Next;
            r_Cnt   <= w_Cnt_Next;
            r_Prev  <= i_Switch;
        end
    end

    // Pending latch: a grant on the same edge frees room for a new event
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Pending <= 1'b0;
            r_Code    <= EV_CLICK;
            r_Drop    <= 1'b0;
        end else begin
            r_Drop <= 1'b0;
            if (w_Emit) begin
                if (r_Pending && !i_Grant) begin
                    r_Drop <= 1'b1;
                end else begin
                    r_Pending <= 1'b1;
                    r_Code    <= w_Emit_Code;
                end
            end else if (i_Grant) begin
                r_Pending <= 1'b0;
            end
        end
    end

    assign o_Pending = r_Pending;
    assign o_Code    = r_Code;
    assign o_Drop    = r_Drop;
    assign o_Held    = (r_State == ST_PRESSED) || (r_State == ST_SECOND_PRESSED) ||
                       (r_State == ST_LONG_HELD);

endmodule

// File: rtl/switch_event_scheduler.sv
// Top level: one classifier per switch, a round-robin arbiter over the
// pending latches and a single valid/ready output register.
module switch_event_scheduler
    import switch_event_pkg::*;
#(
    parameter int NUM_SW    = 4,
    parameter int CLK_HZ    = 25_000_000,
    parameter int LONG_MS   = 1000,
    parameter int DOUBLE_MS = 300,
    localparam int SW_W     = (NUM_SW > 1) ? $clog2(NUM_SW) : 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic              o_Event_Valid,
    input  logic              i_Event_Ready,
    output logic [SW_W-1:0]   o_Event_Sw,
    output logic [1:0]        o_Event_Code,
    output logic [NUM_SW-1:0] o_Drop,
    output logic [NUM_SW-1:0] o_Held
);

    localparam int LONG_CYC   = CLK_HZ / 1000 * LONG_MS;
    localparam int DOUBLE_CYC = CLK_HZ / 1000 * DOUBLE_MS;

    logic [NUM_SW-1:0] w_Pending;
    logic [1:0]        w_Code [NUM_SW];
    logic [NUM_SW-1:0] w_Grant;
    logic              w_Load;
    logic              w_Found;
    logic [SW_W-1:0]   w_Grant_Idx;
    logic [SW_W-1:0]   w_Ptr_Next;
    logic [SW_W-1:0]   r_Ptr;
    logic              r_Valid;
    logic [SW_W-1:0]   r_Sw;
    logic [1:0]        r_Code;

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_chan
        switch_event_fsm #(
            .LONG_CYC   (LONG_CYC),
            .DOUBLE_CYC (DOUBLE_CYC)
        ) u_fsm (
            .i_Clk     (i_Clk),
            .i_Rst     (i_Rst),
            .i_Switch  (i_Switch[gi]),
            .i_Grant   (w_Grant[gi]),
            .o_Pending (w_Pending[gi]),
            .o_Code    (w_Code[gi]),
            .o_Drop    (o_Drop[gi]),
            .o_Held    (o_Held[gi])
        );
    end

    // Output register is free when empty or being consumed this edge
    assign w_Load = !r_Valid || i_Event_Ready;

    // Cyclic search for the first pending channel at or after the pointer
    always_comb begin
        logic [SW_W-1:0] v_Idx;
        w_Found     = 1'b0;
        w_Grant_Idx = '0;
        v_Idx       = '0;
        for (int k = 0; k < NUM_SW; k++) begin
            v_Idx = SW_W'((int'(r_Ptr) + k) % NUM_SW);
            if (!w_Found && w_Pending[v_Idx]) begin
                w_Found     = 1'b1;
                w_Grant_Idx = v_Idx;
            end
        end
    end

    assign w_Grant    = (w_Load && w_Found) ? (NUM_SW'(1) << w_Grant_Idx) : '0;
    assign w_Ptr_Next = (w_Grant_Idx == SW_W'(NUM_SW - 1)) ? '0 : w_Grant_Idx + 1'b1;

    // Output register and round-robin pointer; held while stalled
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Valid <= 1'b0;
            r_Sw    <= '0;
            r_Code  <= EV_CLICK;
            r_Ptr   <= '0;
        end else if (w_Load) begin
            if (w_Found) begin
                r_Valid <= 1'b1;
                r_Sw    <= w_Grant_Idx;
                r_Code  <= w_Code[w_Grant_Idx];
                r_Ptr   <= w_Ptr_Next;
            end else begin
                r_Valid <= 1'b0;
            end
        end
    end

    assign o_Event_Valid = r_Valid;
    assign o_Event_Sw    = r_Sw;
    assign o_Event_Code  = r_Code;

endmodule
